// File: rtl/tl_pkg.sv
// Shared light encoding and default sizing for the traffic-light model.
package tl_pkg;

  localparam logic [1:0] GREEN   = 2'b00;
  localparam logic [1:0] YELLOW  = 2'b01;
  localparam logic [1:0] RED     = 2'b10;
  localparam logic [1:0] ILLEGAL = 2'b11;

  localparam int DEFAULT_CNT_W = 4;

endpackage

// File: rtl/tl_lane_queue.sv
// One lane: saturating vehicle queue drained one car every DEP_GAP green cycles.
module tl_lane_queue
  import tl_pkg::*;
#(
  parameter int CNT_W   = DEFAULT_CNT_W,
  parameter int DEP_GAP = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       light,
  input  logic             arr,
  output logic [CNT_W-1:0] cnt,
  output logic             sensor,
  output logic             ovf
);

  localparam logic [3:0]       TMR_LAST = 4'(DEP_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = '1;

  logic [3:0] tmr;
  logic       green;
  logic       dep;

  assign green  = (light == GREEN);
  assign dep    = green && (cnt != '0) && (tmr == TMR_LAST);
  assign sensor = |cnt;

  // Departure timer: runs only while green with cars waiting, otherwise parked at 0
  always_ff @(posedge clk) begin
    if (reset) begin
      tmr <= 4'd0;
    end else if (!green || cnt == '0 || dep) begin
      tmr <= 4'd0;
    end else begin
      tmr <= tmr + 4'd1;
    end
  end

  // Queue depth and sticky overflow; a simultaneous arrival and departure cancel out
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (arr && !dep) begin
      if (cnt == CNT_FULL) begin
        ovf <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else if (dep && !arr) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/tl_traffic_model.sv
// Intersection model: four lane queues feeding the controller's sensors, plus a light-conflict monitor.
module tl_traffic_model
  import tl_pkg::*;
#(
  parameter int CNT_W   = DEFAULT_CNT_W,
  parameter int DEP_GAP = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       La,
  input  logic [1:0]       Lal,
  input  logic [1:0]       Lb,
  input  logic [1:0]       Lbl,
  input  logic             arr_a,
  input  logic             arr_al,
  input  logic             arr_b,
  input  logic             arr_bl,
  output logic             Ta,
  output logic             Tal,
  output logic             Tb,
  output logic             Tbl,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_al,
  output logic [CNT_W-1:0] cnt_b,
  output logic [CNT_W-1:0] cnt_bl,
  output logic [3:0]       ovf,
  output logic             conflict
);

  tl_lane_queue #(.CNT_W(CNT_W), .DEP_GAP(DEP_GAP)) u_lane_a (
    .clk(clk), .reset(reset), .light(La), .arr(arr_a),
    .cnt(cnt_a), .sensor(Ta), .ovf(ovf[0])
  );

  tl_lane_queue #(.CNT_W(CNT_W), .DEP_GAP(DEP_GAP)) u_lane_al (
    .clk(clk), .reset(reset), .light(Lal), .arr(arr_al),
    .cnt(cnt_al), .sensor(Tal), .ovf(ovf[1])
  );

  tl_lane_queue #(.CNT_W(CNT_W), .DEP_GAP(DEP_GAP)) u_lane_b (
    .clk(clk), .reset(reset), .light(Lb), .arr(arr_b),
    .cnt(cnt_b), .sensor(Tb), .ovf(ovf[2])
  );

  tl_lane_queue #(.CNT_W(CNT_W), .DEP_GAP(DEP_GAP)) u_lane_bl (
    .clk(clk), .reset(reset), .light(Lbl), .arr(arr_bl),
    .cnt(cnt_bl), .sensor(Tbl), .ovf(ovf[3])
  );

  logic [2:0] green_cnt;
  logic       any_illegal;
  logic       bad_lights;

  // Classify the current light combination as unsafe
  always_comb begin
    green_cnt   = 3'd0;
    any_illegal = 1'b0;
    green_cnt   = 3'(La == GREEN) + 3'(Lal == GREEN) + 3'(Lb == GREEN) + 3'(Lbl == GREEN);
    any_illegal = (La == ILLEGAL) || (Lal == ILLEGAL) || (Lb == ILLEGAL) || (Lbl == ILLEGAL);
    bad_lights  = (green_cnt >= 3'd2) || any_illegal;
  end

  // Sticky conflict flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      conflict <= 1'b0;
    end else if (bad_lights) begin
      conflict <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tl_traffic_model.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural lane model.
module tb_tl_traffic_model;

  localparam int CNT_W   = 4;
  localparam int DEP_GAP = 3;
  localparam int CAP     = (1 << CNT_W) - 1;

  localparam logic [1:0] G = 2'b00;
  localparam logic [1:0] Y = 2'b01;
  localparam logic [1:0] R = 2'b10;
  localparam logic [1:0] X = 2'b11;

  logic             clk;
  logic             reset;
  logic [1:0]       lt [4];
  logic [3:0]       arr;
  logic             Ta, Tal, Tb, Tbl;
  logic [CNT_W-1:0] cnt_a, cnt_al, cnt_b, cnt_bl;
  logic [3:0]       ovf;
  logic             conflict;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state: queue depth, cycles of service accumulated toward the next departure
  int m_cnt    [4];
  int m_served [4];
  bit m_ovf    [4];
  bit m_conf;

  tl_traffic_model #(.CNT_W(CNT_W), .DEP_GAP(DEP_GAP)) dut (
    .clk(clk), .reset(reset),
    .La(lt[0]), .Lal(lt[1]), .Lb(lt[2]), .Lbl(lt[3]),
    .arr_a(arr[0]), .arr_al(arr[1]), .arr_b(arr[2]), .arr_bl(arr[3]),
    .Ta(Ta), .Tal(Tal), .Tb(Tb), .Tbl(Tbl),
    .cnt_a(cnt_a), .cnt_al(cnt_al), .cnt_b(cnt_b), .cnt_bl(cnt_bl),
    .ovf(ovf), .conflict(conflict)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the reference model by one clock edge using the inputs that were applied
  task automatic modelUpdate();
    int  greens;
    bit  illegal;
    bit  depart;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        m_cnt[i] = 0; m_served[i] = 0; m_ovf[i] = 0;
      end
      m_conf = 0;
      return;
    end
    greens  = 0;
    illegal = 0;
    for (int i = 0; i < 4; i++) begin
      if (lt[i] == G) greens++;
      if (lt[i] == X) illegal = 1;
    end
    if (greens >= 2 || illegal) m_conf = 1;
    for (int i = 0; i < 4; i++) begin
      bit serving;
      serving = (lt[i] == G) && (m_cnt[i] > 0);
      depart  = serving && (m_served[i] + 1 == DEP_GAP);
      m_served[i] = (serving && !depart) ? m_served[i] + 1 : 0;
      if (arr[i] && !depart) begin
        if (m_cnt[i] == CAP) m_ovf[i] = 1;
        else m_cnt[i]++;
      end else if (depart && !arr[i]) begin
        m_cnt[i]--;
      end
    end
  endtask

  task automatic compareAll();
    checkOutput("cnt_a",    32'(cnt_a),  32'(m_cnt[0]));
    checkOutput("cnt_al",   32'(cnt_al), 32'(m_cnt[1]));
    checkOutput("cnt_b",    32'(cnt_b),  32'(m_cnt[2]));
    checkOutput("cnt_bl",   32'(cnt_bl), 32'(m_cnt[3]));
    checkOutput("Ta",       32'(Ta),     32'(m_cnt[0] != 0));
    checkOutput("Tal",      32'(Tal),    32'(m_cnt[1] != 0));
    checkOutput("Tb",       32'(Tb),     32'(m_cnt[2] != 0));
    checkOutput("Tbl",      32'(Tbl),    32'(m_cnt[3] != 0));
    checkOutput("ovf",      32'(ovf),    32'({m_ovf[3], m_ovf[2], m_ovf[1], m_ovf[0]}));
    checkOutput("conflict", 32'(conflict), 32'(m_conf));
  endtask

  // Drive one cycle of inputs at the falling edge, clock it in, then compare at the next falling edge
  task automatic applyStimulus(input logic rst, input logic [1:0] l0, input logic [1:0] l1,
                               input logic [1:0] l2, input logic [1:0] l3, input logic [3:0] a);
    reset = rst;
    lt[0] = l0; lt[1] = l1; lt[2] = l2; lt[3] = l3;
    arr   = a;
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
    compareAll();
  endtask

  function automatic logic [1:0] pickLight(input bool_green);
    return bool_green ? G : (($urandom_range(0, 3) == 0) ? Y : R);
  endfunction

  initial begin
    reset = 1'b1;
    lt[0] = R; lt[1] = R; lt[2] = R; lt[3] = R;
    arr   = 4'b0;
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = 0; m_served[i] = 0; m_ovf[i] = 0;
    end
    m_conf = 0;
    @(negedge clk);

    applyStimulus(1, R, R, R, R, 4'b0000);
    checkOutput("reset_cnt_a", 32'(cnt_a), 32'd0);
    checkOutput("reset_ovf", 32'(ovf), 32'd0);

    applyStimulus(0, R, R, R, R, 4'b0001);
    checkOutput("first_arr_Ta", 32'(Ta), 32'd1);
    applyStimulus(0, R, R, R, R, 4'b0001);
    applyStimulus(0, R, R, R, R, 4'b0001);
    checkOutput("three_arr_cnt_a", 32'(cnt_a), 32'd3);

    for (int c = 0; c < 9; c++) begin
      applyStimulus(0, G, R, R, R, 4'b0000);
      if (c == 2) checkOutput("drain_step1", 32'(cnt_a), 32'd2);
      if (c == 5) checkOutput("drain_step2", 32'(cnt_a), 32'd1);
    end
    checkOutput("drain_empty", 32'(cnt_a), 32'd0);
    checkOutput("drain_Ta_low", 32'(Ta), 32'd0);

    applyStimulus(0, R, R, R, R, 4'b0100);
    applyStimulus(0, R, R, R, R, 4'b0100);
    applyStimulus(0, R, R, G, R, 4'b0000);
    applyStimulus(0, R, R, G, R, 4'b0000);
    applyStimulus(0, R, R, G, R, 4'b0100);
    checkOutput("arr_on_dep_cnt_b", 32'(cnt_b), 32'd2);
    applyStimulus(0, R, R, R, R, 4'b0000);

    for (int c = 0; c < CAP; c++) applyStimulus(0, R, R, R, R, 4'b0010);
    checkOutput("full_cnt_al", 32'(cnt_al), 32'(CAP));
    applyStimulus(0, R, R, R, R, 4'b0010);
    checkOutput("full_hold_cnt_al", 32'(cnt_al), 32'(CAP));
    checkOutput("full_ovf", 32'(ovf), 32'b0010);

    applyStimulus(0, R, R, R, R, 4'b1000);
    applyStimulus(0, R, R, R, G, 4'b0000);
    applyStimulus(0, R, R, R, G, 4'b0000);
    applyStimulus(0, R, R, R, Y, 4'b0000);
    applyStimulus(0, R, R, R, G, 4'b0000);
    applyStimulus(0, R, R, R, G, 4'b0000);
    checkOutput("interrupted_hold", 32'(cnt_bl), 32'd1);
    applyStimulus(0, R, R, R, G, 4'b0000);
    checkOutput("interrupted_dep", 32'(cnt_bl), 32'd0);

    applyStimulus(0, G, R, G, R, 4'b0000);
    checkOutput("conflict_set", 32'(conflict), 32'd1);
    applyStimulus(0, R, R, R, R, 4'b0000);
    checkOutput("conflict_sticky", 32'(conflict), 32'd1);

    applyStimulus(1, R, R, R, R, 4'b1111);
    checkOutput("midreset_cnt_al", 32'(cnt_al), 32'd0);
    checkOutput("midreset_Tb", 32'(Tb), 32'd0);
    checkOutput("midreset_ovf", 32'(ovf), 32'd0);
    checkOutput("midreset_conflict", 32'(conflict), 32'd0);

    applyStimulus(0, R, X, R, R, 4'b0000);
    checkOutput("illegal_conflict", 32'(conflict), 32'd1);

    // Randomized traffic: hold a light pattern for a while, periodically reset
    for (int seg = 0; seg < 300; seg++) begin
      logic [1:0] l [4];
      int         hold;
      int         gl;
      bit         do_reset;
      do_reset = ($urandom_range(0, 24) == 0);
      gl = $urandom_range(0, 4);
      for (int i = 0; i < 4; i++) l[i] = pickLight(i == gl);
      if ($urandom_range(0, 39) == 0) l[$urandom_range(0, 3)] = ($urandom_range(0, 1) != 0) ? X : G;
      hold = $urandom_range(1, 12);
      for (int c = 0; c < hold; c++) begin
        logic [3:0] a;
        for (int i = 0; i < 4; i++) a[i] = ($urandom_range(0, 9) < 3);
        applyStimulus(do_reset && c == 0, l[0], l[1], l[2], l[3], a);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
